// File: rtl/branch_history_table_pkg.sv
// Shared predictor definitions: 2-bit counter encoding and its saturating
// next-state function. Also used by the saturating-counter predictor stage.
package bp_pkg;

    localparam int CTR_W = 2;

    typedef logic [CTR_W-1:0] ctr_t;

    localparam ctr_t ST_T  = 2'b11;  // strongly taken
    localparam ctr_t ST_T1 = 2'b10;  // weakly taken
    localparam ctr_t ST_N1 = 2'b01;  // weakly not-taken
    localparam ctr_t ST_N  = 2'b00;  // strongly not-taken

    // Saturating step toward the resolved outcome; never wraps.
    function automatic ctr_t ctr_next(input ctr_t ctr, input logic taken);
        ctr_t nxt;
        case (ctr)
            ST_N:    nxt = taken ? ST_N1 : ST_N;
            ST_N1:   nxt = taken ? ST_T1 : ST_N;
            ST_T1:   nxt = taken ? ST_T  : ST_N1;
            ST_T:    nxt = taken ? ST_T  : ST_T1;
            default: nxt = ctr;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/branch_history_table_if.sv
// Lookup and update ports of the branch history table.
// master = requester side (predictor / branch resolution), slave = table.
interface branch_history_table_if #(
    parameter int INDEX_BITS = 6
);
    import bp_pkg::*;

    logic                  lkp_valid;
    logic [INDEX_BITS-1:0] lkp_index;
    logic                  pred_valid;
    ctr_t                  pred_counter;
    logic                  pred_taken;

    logic                  upd_valid;
    logic                  upd_ready;
    logic [INDEX_BITS-1:0] upd_index;
    logic                  upd_taken;
    logic                  upd_pending;

    modport master (
        output lkp_valid, lkp_index, upd_valid, upd_index, upd_taken,
        input  pred_valid, pred_counter, pred_taken, upd_ready, upd_pending
    );

    modport slave (
        input  lkp_valid, lkp_index, upd_valid, upd_index, upd_taken,
        output pred_valid, pred_counter, pred_taken, upd_ready, upd_pending
    );

endinterface

// File: rtl/branch_history_table_update_fifo.sv
// Small circular FIFO buffering resolved branch outcomes ({index, taken})
// until the table can apply them. Push is ignored when full, pop when empty.
// flush_i empties the FIFO and has priority over push/pop.
module bht_update_fifo #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 7
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic                         flush_i,
    input  logic                         push_i,
    input  logic [DATA_W-1:0]            push_data_i,
    input  logic                         pop_i,
    output logic [DATA_W-1:0]            pop_data_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         full_o,
    output logic                         empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push_s;
    logic              do_pop_s;

    assign full_o     = (count_q == CNT_W'(DEPTH));
    assign empty_o    = (count_q == {CNT_W{1'b0}});
    assign count_o    = count_q;
    assign pop_data_o = mem_q[rd_ptr_q];
    assign do_push_s  = push_i && !full_o;
    assign do_pop_s   = pop_i && !empty_o;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            count_d  = {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                mem_d[wr_ptr_q] = push_data_i;
                wr_ptr_d        = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // FIFO state registers; reset empties the queue.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {DATA_W{1'b0}};
            end
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/branch_history_table.sv
// Pattern history table of 2-bit saturating counters.
// Registered lookup (latency 1) reads the table as it stood before any
// same-cycle drain write. Resolved outcomes enter a small FIFO and are
// drained one per cycle with a read-modify-write; buffered updates are
// not visible to lookups. clear reinitialises everything synchronously.
module branch_history_table
    import bp_pkg::*;
#(
    parameter int   INDEX_BITS = 6,
    parameter int   UPD_DEPTH  = 2,
    parameter ctr_t INIT_STATE = 2'b11
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  clear,
    branch_history_table_if.slave bus
);

    localparam int ENTRIES = 2 ** INDEX_BITS;
    localparam int CNT_W   = $clog2(UPD_DEPTH+1);
    localparam int DATA_W  = INDEX_BITS + 1;

    ctr_t                  table_q [ENTRIES];
    ctr_t                  table_d [ENTRIES];
    logic                  pred_valid_q, pred_valid_d;
    ctr_t                  pred_counter_q, pred_counter_d;

    logic                  push_s;
    logic                  pop_s;
    logic [DATA_W-1:0]     push_data_s;
    logic [DATA_W-1:0]     pop_data_s;
    logic [CNT_W-1:0]      fifo_count_s;
    logic                  fifo_full_s;
    logic                  fifo_empty_s;
    logic [INDEX_BITS-1:0] head_index_s;
    logic                  head_taken_s;

    // Updates offered during clear are dropped; ready depends only on the
    // registered count, so a full FIFO refuses even when draining.
    assign push_s       = bus.upd_valid && !fifo_full_s && !clear;
    assign pop_s        = !fifo_empty_s && !clear;
    assign push_data_s  = {bus.upd_index, bus.upd_taken};
    assign head_index_s = pop_data_s[DATA_W-1:1];
    assign head_taken_s = pop_data_s[0];

    bht_update_fifo #(
        .DEPTH  (UPD_DEPTH),
        .DATA_W (DATA_W)
    ) u_upd_fifo (
        .clk_i       (clock),
        .rst_n_i     (reset_n),
        .flush_i     (clear),
        .push_i      (push_s),
        .push_data_i (push_data_s),
        .pop_i       (pop_s),
        .pop_data_o  (pop_data_s),
        .count_o     (fifo_count_s),
        .full_o      (fifo_full_s),
        .empty_o     (fifo_empty_s)
    );

    // Table next-state: clear reloads every entry, otherwise apply the drained update.
    always_comb begin
        table_d = table_q;
        if (clear) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_d[i] = INIT_STATE;
            end
        end else if (pop_s) begin
            table_d[head_index_s] = ctr_next(table_q[head_index_s], head_taken_s);
        end else begin
            table_d = table_q;
        end
    end

    // Counter table storage.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= INIT_STATE;
            end
        end else begin
            table_q <= table_d;
        end
    end

    // Lookup next-state: read pre-write table value; hold counter when idle or clearing.
    always_comb begin
        pred_valid_d   = 1'b0;
        pred_counter_d = pred_counter_q;
        if (clear) begin
            pred_valid_d   = 1'b0;
            pred_counter_d = pred_counter_q;
        end else if (bus.lkp_valid) begin
            pred_valid_d   = 1'b1;
            pred_counter_d = table_q[bus.lkp_index];
        end else begin
            pred_valid_d   = 1'b0;
            pred_counter_d = pred_counter_q;
        end
    end

    // Lookup result registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pred_valid_q   <= 1'b0;
            pred_counter_q <= 2'b00;
        end else begin
            pred_valid_q   <= pred_valid_d;
            pred_counter_q <= pred_counter_d;
        end
    end

    assign bus.pred_valid   = pred_valid_q;
    assign bus.pred_counter = pred_counter_q;
    assign bus.pred_taken   = pred_counter_q[1];
    assign bus.upd_ready    = (fifo_count_s < CNT_W'(UPD_DEPTH));
    assign bus.upd_pending  = (fifo_count_s != {CNT_W{1'b0}});

endmodule
